// File: rtl/mem_data_buf.sv
// Load-data buffer: extracts and extends the accessed field at push, then queues it in a circular FIFO.
// Define MEM_DATA_BUF_ALIGN_CHECK_EN to build the sticky misaligned-access flag.
module mem_data_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int OFF_W     = $clog2(DATA_WIDTH / 8),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_size,
  input  logic                  in_sign,
  input  logic [OFF_W-1:0]      in_offset,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      count,
  output logic                  misalign
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] field_mask;
  logic [DATA_WIDTH-1:0] msb_mask;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [31:0]           field_bits;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Shifting right brings the field to bit 0; bytes past the word end shift in as zero.
  always_comb begin
    shifted    = in_data >> {in_offset, 3'b000};
    field_bits = 32'd8 << in_size;
    if (field_bits >= DATA_WIDTH) begin
      field_mask = '1;
    end else begin
      field_mask = (DATA_WIDTH'(1) << field_bits) - DATA_WIDTH'(1);
    end
    msb_mask = field_mask & ~(field_mask >> 1);
    if (DATA_WIDTH == 32 && (in_size == 2'b11 || (in_size == 2'b10 && in_sign))) begin
      ext_data = in_data;
    end else if (in_sign && |(shifted & msb_mask)) begin
      ext_data = shifted | ~field_mask;
    end else begin
      ext_data = shifted & field_mask;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= ext_data;
    end
  end

`ifdef MEM_DATA_BUF_ALIGN_CHECK_EN
  logic       misalign_q, misalign_d;
  logic [2:0] off_ext;
  logic [2:0] size_low;

  always_comb begin
    off_ext    = 3'(in_offset);
    size_low   = (3'd1 << in_size) - 3'd1;
    misalign_d = misalign_q | (push && ((off_ext & size_low) != 3'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_data_buf.sv
// Self-checking bench for mem_data_buf (DATA_WIDTH=32, DEPTH=2) against a byte-level queue model.
module tb_mem_data_buf;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int OFF_W = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_sign = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic [1:0]       in_size = '0;
  logic [OFF_W-1:0] in_offset = '0;
  logic             in_ready, out_valid, misalign;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] mq[$];
  bit            m_mis = 1'b0;

`ifdef MEM_DATA_BUF_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_data_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_size(in_size), .in_sign(in_sign), .in_offset(in_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .misalign(misalign)
  );

  // Field gathered byte by byte, zero past the word end, then extended.
  function automatic logic [DW-1:0] model_extract(logic [DW-1:0] data, logic [1:0] size,
                                                  logic sign, logic [OFF_W-1:0] off);
    int nbytes;
    logic [63:0] f;
    nbytes = 1 << size;
    if (size == 2'd3 || (size == 2'd2 && sign)) return data;
    f = '0;
    for (int b = 0; b < nbytes; b++)
      if (int'(off) + b < DW / 8) f[b*8 +: 8] = data[(int'(off) + b)*8 +: 8];
    if (sign && f[nbytes*8-1])
      for (int i = nbytes * 8; i < 64; i++) f[i] = 1'b1;
    return f[DW-1:0];
  endfunction

  // Advances the model by the handshakes implied by current inputs, then one clock edge.
  task automatic clock_step();
    bit push, pop;
    logic [DW-1:0] v;
    push = in_valid && (mq.size() < DEPTH);
    pop  = out_ready && (mq.size() > 0);
    v    = model_extract(in_data, in_size, in_sign, in_offset);
    if (rst) begin
      mq.delete();
      m_mis = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(v);
        if (ALIGN_EN && (int'(in_offset) % (1 << in_size)) != 0) m_mis = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [DW-1:0] d, logic [1:0] s, logic sg, logic [OFF_W-1:0] o);
    in_data = d; in_size = s; in_sign = sg; in_offset = o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clock_step();
    clock_step();
    rst = 1'b0;
    n_checks++;
    if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++;
    if (misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign); else n_pass++;
    $display("test_reset: count=%0d out_valid=%b in_ready=%b", count, out_valid, in_ready);
  endtask

  task automatic test_extract();
    logic [DW-1:0] want [3];
    logic [1:0]    sz [3];
    logic          sg [3];
    want[0] = 32'hFFFF_FFFF; sz[0] = 2'd0; sg[0] = 1'b1;
    want[1] = 32'h0000_80FF; sz[1] = 2'd1; sg[1] = 1'b0;
    want[2] = 32'hFFFF_80FF; sz[2] = 2'd1; sg[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(32'h80FF_7F01, sz[k], sg[k], 2'd2);
      clock_step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL extract%0d_valid: got %b want 1", k, out_valid); else n_pass++;
      n_checks++;
      if (out_data !== want[k]) $display("FAIL extract%0d_data: got %h want %h", k, out_data, want[k]);
      else n_pass++;
      $display("test_extract[%0d]: size=%0d sign=%b -> out_data=%h", k, sz[k], sg[k], out_data);
      out_ready = 1'b1;
      clock_step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] a, b;
    a = $urandom; b = $urandom;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(a, 2'd2, 1'b0, 2'd0); clock_step();
    drive(b, 2'd2, 1'b0, 2'd0); clock_step();
    n_checks++;
    if (count !== 2'd2) $display("FAIL full_count: got %0d want 2", count); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else n_pass++;
    drive(~a, 2'd2, 1'b0, 2'd0); clock_step();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 2'd2) $display("FAIL full_ignored_count: got %0d want 2", count); else n_pass++;
    n_checks++;
    if (out_data !== a) $display("FAIL full_head_a: got %h want %h", out_data, a); else n_pass++;
    out_ready = 1'b1;
    clock_step();
    n_checks++;
    if (out_data !== b || count !== 2'd1)
      $display("FAIL full_head_b: got %h/%0d want %h/1", out_data, count, b);
    else n_pass++;
    clock_step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL full_drained: got %b want 0", out_valid); else n_pass++;
    out_ready = 1'b0;
    $display("test_full: a=%h b=%h drained count=%0d", a, b, count);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive($urandom, 2'd2, 1'b0, 2'd0);
    clock_step();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      clock_step();
      n_checks++;
      if (count !== 2'd1) $display("FAIL b2b%0d_count: got %0d want 1", k, count); else n_pass++;
      n_checks++;
      if (mq.size() != 1 || out_data !== mq[0])
        $display("FAIL b2b%0d_data: got %h want %h", k, out_data, mq[0]);
      else n_pass++;
      $display("test_back_to_back[%0d]: count=%0d out_data=%h", k, count, out_data);
    end
    in_valid = 1'b0;
    clock_step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive($urandom, 2'd0, 1'b1, 2'd1); clock_step();
    drive($urandom, 2'd2, 1'b0, 2'd1); clock_step();
    n_checks++;
    if (count !== 2'd2) $display("FAIL rstmid_pre_count: got %0d want 2", count); else n_pass++;
    out_ready = 1'b1;
    rst = 1'b1;
    clock_step();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || misalign !== 1'b0)
      $display("FAIL rstmid_state: got count=%0d ov=%b ir=%b mis=%b want 0/0/1/0",
               count, out_valid, in_ready, misalign);
    else n_pass++;
    clock_step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_idle: got %b want 0", out_valid); else n_pass++;
    $display("test_reset_mid: count=%0d out_valid=%b", count, out_valid);
  endtask

  task automatic test_misalign();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive($urandom, 2'd2, 1'b0, 2'd1); clock_step();
    n_checks++;
    if (misalign !== ALIGN_EN) $display("FAIL misalign_set: got %b want %b", misalign, ALIGN_EN); else n_pass++;
    drive($urandom, 2'd2, 1'b0, 2'd0); clock_step();
    drive($urandom, 2'd0, 1'b0, 2'd3); clock_step();
    in_valid = 1'b0;
    clock_step();
    n_checks++;
    if (misalign !== ALIGN_EN) $display("FAIL misalign_sticky: got %b want %b", misalign, ALIGN_EN); else n_pass++;
    rst = 1'b1;
    clock_step();
    rst = 1'b0;
    n_checks++;
    if (misalign !== 1'b0) $display("FAIL misalign_clear: got %b want 0", misalign); else n_pass++;
    out_ready = 1'b0;
    $display("test_misalign: align_en=%b misalign=%b", ALIGN_EN, misalign);
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_checks - n_pass;
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 39) == 0);
      drive($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      clock_step();
      n_checks++;
      if (count !== CNT_W'(mq.size())) $display("FAIL rand%0d_count: got %0d want %0d", k, count, mq.size());
      else n_pass++;
      n_checks++;
      if (in_ready !== (mq.size() != DEPTH)) $display("FAIL rand%0d_in_ready: got %b", k, in_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== (mq.size() != 0)) $display("FAIL rand%0d_out_valid: got %b", k, out_valid);
      else n_pass++;
      n_checks++;
      if (misalign !== m_mis) $display("FAIL rand%0d_misalign: got %b want %b", k, misalign, m_mis);
      else n_pass++;
      if (mq.size() != 0) begin
        n_checks++;
        if (out_data !== mq[0]) $display("FAIL rand%0d_data: got %h want %h", k, out_data, mq[0]);
        else n_pass++;
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("test_random: 400 cycles, %0d new mismatching checks", (n_checks - n_pass) - errs_before);
  endtask

  initial begin
    test_reset();
    test_extract();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
